// File: rtl/data_mem_pkg.sv
// +----------------------------------------------------------------------------+
// | data_mem_pkg : shared types and constants for the data memory sequencer    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package data_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int RAM_READ_LATENCY = 1;

endpackage

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// +----------------------------------------------------------------------------+
// | data_mem_ctrl : read-then-optional-write sequencer between the memory stage|
// | and a 1-cycle-latency single-port data RAM; stalls the pipeline meanwhile. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_Clk_1,
    input  logic                  i_Rst_1,
    input  logic                  i_ReqLoad_1,
    input  logic                  i_ReqStore_1,
    input  logic [31:0]           i_ReqAddr_32,
    input  logic [31:0]           i_ReqStoreData_32,
    output logic [31:0]           o_LoadData_32,
    output logic                  o_Stall_1,
    output logic                  o_AddrFault_1,
    output logic [ADDR_WIDTH-1:0] o_RamAddr_ADDR_WIDTH,
    output logic                  o_RamRe_1,
    output logic                  o_RamWe_1,
    output logic [31:0]           o_RamWData_32,
    input  logic [31:0]           i_RamRData_32
);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic                    is_store_q, is_store_d;
    logic [31:0]             load_data_q, load_data_d;
    logic                    fault_q, fault_d;

    logic                    w_valid;
    logic                    w_fault;
    logic [31:0]             w_hi_bits;
    logic [ADDR_WIDTH-1:0]   w_req_idx;

    logic                    w_stall;
    logic                    w_re;
    logic                    w_we;
    logic                    w_afault;
    logic [ADDR_WIDTH-1:0]   w_ram_addr;
    logic [31:0]             w_wdata;

    assign w_valid   = i_ReqLoad_1 | i_ReqStore_1;
    // Shift rather than slice so the check stays legal for any ADDR_WIDTH.
    assign w_hi_bits = i_ReqAddr_32 >> (ADDR_WIDTH + 2);
    assign w_fault   = |w_hi_bits;
    assign w_req_idx = i_ReqAddr_32[ADDR_WIDTH+1:2];

    always_ff @(posedge i_Clk_1 or posedge i_Rst_1) begin
        if (i_Rst_1) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            is_store_q  <= 1'b0;
            load_data_q <= 32'd0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            is_store_q  <= is_store_d;
            load_data_q <= load_data_d;
            fault_q     <= fault_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        is_store_d  = is_store_q;
        load_data_d = load_data_q;
        fault_d     = fault_q;
        w_stall     = 1'b0;
        w_re        = 1'b0;
        w_we        = 1'b0;
        w_afault    = 1'b0;
        w_ram_addr  = '0;
        w_wdata     = 32'd0;

        unique case (state_q)
            ST_IDLE: begin
                if (w_valid) begin
                    w_stall = 1'b1;
                    if (w_fault) begin
                        load_data_d = 32'd0;
                        fault_d     = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        w_re       = 1'b1;
                        w_ram_addr = w_req_idx;
                        idx_d      = w_req_idx;
                        is_store_d = i_ReqStore_1;
                        state_d    = ST_READ;
                    end
                end
            end
            ST_READ: begin
                w_stall     = 1'b1;
                load_data_d = i_RamRData_32;
                state_d     = is_store_q ? ST_WRITE : ST_DONE;
            end
            ST_WRITE: begin
                // Store data is merged upstream from the word captured in READ.
                w_stall    = 1'b1;
                w_we       = 1'b1;
                w_ram_addr = idx_q;
                w_wdata    = i_ReqStoreData_32;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                w_afault = fault_q;
                fault_d  = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Mask live-request terms so outputs show reset values while reset is held.
    assign o_Stall_1            = w_stall & ~i_Rst_1;
    assign o_RamRe_1            = w_re & ~i_Rst_1;
    assign o_RamWe_1            = w_we & ~i_Rst_1;
    assign o_AddrFault_1        = w_afault & ~i_Rst_1;
    assign o_RamAddr_ADDR_WIDTH = i_Rst_1 ? '0 : w_ram_addr;
    assign o_RamWData_32        = i_Rst_1 ? 32'd0 : w_wdata;
    assign o_LoadData_32        = load_data_q;

endmodule

`default_nettype wire
